serial_subtractor: RTL
======================

# serial_subtractor

Bit-serial subtractor computing `{b_out, d} = a - b - b_in` over WIDTH clock cycles, one bit per cycle, through a single full-subtractor cell. It is the subtraction counterpart of the generate-based ripple adder. It is used where area matters more than latency, and its results are cross-checked against that adder (`a == d + b + b_in` with carry equal to `b_out`). A start/busy/done handshake frames each operation.

## Interface
- `WIDTH`, default 4: operand and result width in bits (≥ 2).

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `start`  in  1  request; sampled on the rising edge.
- `a`  in  WIDTH  minuend; captured when `start` is accepted.
- `b`  in  WIDTH  subtrahend; captured when `start` is accepted.
- `b_in`  in  1  borrow in; captured when `start` is accepted.
- `busy`  out  1  high while bits are being processed.
- `done`  out  1  one-cycle pulse: result valid.
- `d`  out  WIDTH  difference; registered, held until the next result.
- `b_out`  out  1  borrow out; registered, held until the next result.

## Operation
- **Reset** (`rst_n` = 0, any time, including mid-operation):
  - state returns to IDLE;
  - `busy`, `done`, `d`, `b_out`, the shift registers and the bit counter all clear to 0;
  - the operation in flight is discarded; there is no partial result.
- **FSM states:** IDLE, RUN, DONE.
  - IDLE → RUN when `start` = 1. On this transition:
    - `a` and `b` load into the operand shift registers;
    - `b_in` loads into the borrow register;
    - the bit counter is set to 0.
  - RUN, one bit per cycle:
    - The cell takes operand LSBs `a0`, `b0` and the borrow register `br`.
    - `diff = a0 ^ b0 ^ br`.
    - `bo = (~a0 & b0) | (~(a0 ^ b0) & br)`.
    - The operand registers shift right by 1.
    - `diff` shifts into the MSB of the internal result register.
    - `br <= bo`; the counter increments.
  - RUN → DONE on the edge where the counter equals WIDTH-1. On that edge:
    - `d` loads the completed result register, including the final `diff`;
    - `b_out` loads the final `bo`.
  - DONE → IDLE when `start` = 0.
  - DONE → RUN when `start` = 1: back-to-back acceptance, with the same capture as from IDLE.
- **Ignored start:** `start` in RUN has no effect; it is neither queued nor an error.
- **Outputs:**
  - `busy` = (state == RUN).
  - `done` = (state == DONE).
  - `d` and `b_out` change only on the RUN → DONE edge or on reset.
  - Intermediate shift contents are never visible on `d`.
- **Arithmetic:**
  - `d = (a - b - b_in) mod 2^WIDTH`.
  - `b_out = 1` iff `a < b + b_in` (unsigned).
  - Identity: `a + 2^WIDTH·b_out = b + b_in + d`.
- **Input changes:** changes on `a`, `b` or `b_in` after capture do not affect the operation in flight.

## Timing
- Edge 0: `start` accepted; `busy` = 1 from edge 0.
- Edges 1..WIDTH: bit i is processed on edge i+1.
- Edge WIDTH:
  - `d` and `b_out` update;
  - `busy` = 0;
  - `done` = 1 for exactly one cycle (edge WIDTH to edge WIDTH+1).
- Latency: WIDTH cycles from the accept edge to the result edge.
- Throughput: with `start` held high, one result per WIDTH+1 cycles.
- Reset deassertion: the first edge with `rst_n` = 1 may accept `start`.

## Structure
- **Package `serial_sub_pkg`:**
  - state encoding constants: `ST_IDLE` = 2'd0, `ST_RUN` = 2'd1, `ST_DONE` = 2'd2;
  - counter width `CNT_W = $clog2(WIDTH)`, derived from the parameter.
- **Sub-module `full_subtractor`:**
  - purely combinational;
  - ports `a`, `b`, `b_in`, `d`, `b_out`;
  - instantiated once; the testbench can probe it hierarchically per cycle.
- **Top level:** FSM, counter, two operand shift registers, result shift register, borrow flop, output registers.

## Test plan
All scenarios use WIDTH = 4.
- **Reset values:** assert `rst_n` = 0 → `busy`, `done`, `d`, `b_out` all 0. After release with `start` = 0 → state stays IDLE and outputs stay 0.
- **Simple subtract:** `a`=9, `b`=3, `b_in`=0, `start` pulse → `busy` for 4 cycles; `done` one cycle after edge 4; `d`=0110, `b_out`=0.
- **Borrow cases:**
  - `a`=3, `b`=9, `b_in`=1 → `d`=1001, `b_out`=1.
  - `a`=0, `b`=0, `b_in`=1 → `d`=1111, `b_out`=1.
  - `a`=15, `b`=15, `b_in`=0 → `d`=0000, `b_out`=0.
- **Handshake:**
  - `start` held high and operands changed during RUN → ignored; the result matches the captured operands.
  - `start` high during DONE → the new operation begins at once; `done` pulses every 5 cycles.
- **Reset mid-operation:** `rst_n` low after 2 RUN edges → immediate IDLE, all outputs 0. Then `a`=5, `b`=2, `b_in`=0 → `d`=0011, `b_out`=0.
- **Exhaustive:** drive `{a, b, b_in}` from a 9-bit counter through all 512 values → every result satisfies `a + 16·b_out == b + b_in + d`.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// rtl/serial_sub_pkg.sv - shared state encoding and sizing helper for the bit-serial subtractor
package serial_sub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Bit-counter width for a given operand width; never narrower than one bit.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// rtl/full_subtractor.sv - single-bit combinational full subtractor cell
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic b_in,
  output logic d,
  output logic b_out
);

  assign d     = a ^ b ^ b_in;
  assign b_out = (~a & b) | (~(a ^ b) & b_in);

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial a - b - b_in, LSB first, one bit per clock through one cell
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             b_out
);

  localparam int               CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-2:0] res_sh;
  logic [CNT_W-1:0] cnt;
  logic             br;
  logic             cell_d;
  logic             cell_bo;
  logic [WIDTH-1:0] res_next;

  full_subtractor u_cell (
    .a     (a_sh[0]),
    .b     (b_sh[0]),
    .b_in  (br),
    .d     (cell_d),
    .b_out (cell_bo)
  );

  // Only WIDTH-1 partial bits are stored; the last diff goes straight into d.
  assign res_next = {cell_d, res_sh};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      cnt    <= '0;
      br     <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      d      <= '0;
      b_out  <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          res_sh <= res_next[WIDTH-1:1];
          br     <= cell_bo;
          cnt    <= cnt + CNT_W'(1);
          if (cnt == LAST_BIT) begin
            d     <= res_next;
            b_out <= cell_bo;
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          // IDLE and DONE accept a new request identically.
          done <= 1'b0;
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            br    <= b_in;
            cnt   <= '0;
            state <= ST_RUN;
            busy  <= 1'b1;
          end else begin
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule
